// File: rtl/btn_pio_pkg.sv
// ============================================================================
// Module      : btn_pio_pkg
// Description : PIO register map, sequencer state encoding and event record
//               shared by the button PIO interrupt sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA     = 2'd0;
    localparam logic [1:0] PIO_ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE_CAP = 2'd3;

    typedef enum logic [3:0] {
        INIT_MASK = 4'd0,
        INIT_CLR  = 4'd1,
        IDLE      = 4'd2,
        MASK_WR   = 4'd3,
        RD_EDGE   = 4'd4,
        WAIT_EDGE = 4'd5,
        CLR_EDGE  = 4'd6,
        RD_DATA   = 4'd7,
        WAIT_DATA = 4'd8,
        EMIT      = 4'd9
    } seq_state_t;

    // Fields sized for the widest supported PIO (32 buttons).
    typedef struct packed {
        logic [31:0] edges;
        logic [31:0] level;
        logic [31:0] timestamp;
    } btn_evt_t;

endpackage

`default_nettype wire

// File: rtl/button_pio_irq_sequencer.sv
// ============================================================================
// Module      : button_pio_irq_sequencer
// Description : Avalon-MM master owning the button PIO: programs the IRQ mask,
//               services edge interrupts and emits one event per service.
//               Optional macro BTN_EVT_TIMESTAMP_EN adds a cycle timestamp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_pio_irq_sequencer
    import btn_pio_pkg::*;
#(
    parameter int unsigned      WIDTH         = 4,
    parameter logic [WIDTH-1:0] IRQ_MASK_INIT = 4'hF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq_in,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    input  logic             mask_wr_valid,
    input  logic [WIDTH-1:0] mask_wr_data,
    output logic             mask_wr_ready,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_edges,
    output logic [WIDTH-1:0] evt_level,
    output logic [31:0]      evt_timestamp,
    output logic             busy
);

    localparam logic [31:0] c_clr_all = 32'({WIDTH{1'b1}});

    seq_state_t  r_state;
    seq_state_t  w_next;
    logic        r_launched;
    btn_evt_t    r_evt;
    logic [1:0]  w_addr;
    logic        w_cs;
    logic        w_wr_n;
    logic [31:0] w_wdata;
    logic [31:0] w_stamp;
    logic        w_unused_bits;

`ifdef BTN_EVT_TIMESTAMP_EN
    logic [31:0] r_cycle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_cycle_cnt <= '0;
        else       r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end

    assign w_stamp = r_cycle_cnt;
`else
    assign w_stamp = '0;
`endif

    // INIT_MASK idles one cycle after reset so its write gets its own bus cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            INIT_MASK: if (r_launched) w_next = INIT_CLR;
            INIT_CLR:  w_next = IDLE;
            IDLE: begin
                if (mask_wr_valid) w_next = MASK_WR;
                else if (irq_in)   w_next = RD_EDGE;
            end
            MASK_WR:   w_next = IDLE;
            RD_EDGE:   w_next = WAIT_EDGE;
            WAIT_EDGE: w_next = (avm_readdata[WIDTH-1:0] == '0) ? IDLE : CLR_EDGE;
            CLR_EDGE:  w_next = RD_DATA;
            RD_DATA:   w_next = WAIT_DATA;
            WAIT_DATA: w_next = EMIT;
            EMIT:      if (evt_ready) w_next = IDLE;
            default:   w_next = INIT_MASK;
        endcase
    end

    // Bus registers are loaded from the upcoming state, so each state owns
    // exactly the bus cycle it is resident in.
    always_comb begin
        w_addr  = PIO_ADDR_DATA;
        w_cs    = 1'b0;
        w_wr_n  = 1'b1;
        w_wdata = '0;
        case (w_next)
            INIT_MASK: begin
                w_addr  = PIO_ADDR_IRQ_MASK;
                w_cs    = 1'b1;
                w_wr_n  = 1'b0;
                w_wdata = 32'(IRQ_MASK_INIT);
            end
            MASK_WR: begin
                w_addr  = PIO_ADDR_IRQ_MASK;
                w_cs    = 1'b1;
                w_wr_n  = 1'b0;
                w_wdata = 32'(mask_wr_data);
            end
            INIT_CLR, CLR_EDGE: begin
                w_addr  = PIO_ADDR_EDGE_CAP;
                w_cs    = 1'b1;
                w_wr_n  = 1'b0;
                w_wdata = c_clr_all;
            end
            RD_EDGE: w_addr = PIO_ADDR_EDGE_CAP;
            RD_DATA: w_addr = PIO_ADDR_DATA;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= INIT_MASK;
            r_launched     <= 1'b0;
            avm_address    <= PIO_ADDR_DATA;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
            r_evt          <= '0;
        end else begin
            r_state        <= w_next;
            r_launched     <= 1'b1;
            avm_address    <= w_addr;
            avm_chipselect <= w_cs;
            avm_write_n    <= w_wr_n;
            avm_writedata  <= w_wdata;
            if (r_state == WAIT_EDGE) begin
                r_evt.edges     <= 32'(avm_readdata[WIDTH-1:0]);
                r_evt.timestamp <= w_stamp;
            end
            if (r_state == WAIT_DATA) begin
                r_evt.level <= 32'(avm_readdata[WIDTH-1:0]);
            end
        end
    end

    assign mask_wr_ready = (r_state == IDLE) && mask_wr_valid;
    assign evt_valid     = (r_state == EMIT);
    assign busy          = (r_state != IDLE);
    assign evt_edges     = r_evt.edges[WIDTH-1:0];
    assign evt_level     = r_evt.level[WIDTH-1:0];
    assign evt_timestamp = r_evt.timestamp;

    assign w_unused_bits = ^{avm_readdata, r_evt.edges, r_evt.level};

endmodule

`default_nettype wire

// File: tb/tb_button_pio_irq_sequencer.sv
// ============================================================================
// Module      : tb_button_pio_irq_sequencer
// Description : Self-checking bench with a PIO slave model and an event-level
//               reference model of the button interrupt sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_pio_irq_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] pio_rdata = '0;
    logic        mask_wr_valid = 1'b0;
    logic [3:0]  mask_wr_data = '0;
    logic        mask_wr_ready;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [3:0]  evt_edges;
    logic [3:0]  evt_level;
    logic [31:0] evt_timestamp;
    logic        busy;
    logic        irq_in;

    // PIO slave model state
    logic [3:0]  pio_edge = '0;
    logic [3:0]  pio_mask = '0;
    logic [3:0]  pio_level = '0;
    logic [3:0]  press_pulse = '0;
    logic        force_irq = 1'b0;
    logic [33:0] wr_log[$];
    logic [31:0] tb_cyc;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: sticky pending edges and current mask
    logic [3:0] pending = '0;
    logic [3:0] cur_mask = 4'hF;

    always #5 clk = ~clk;

    assign irq_in = (|(pio_edge & pio_mask)) | force_irq;

    always @(posedge clk) begin
        case (avm_address)
            2'd0:    pio_rdata <= {28'd0, pio_level};
            2'd2:    pio_rdata <= {28'd0, pio_mask};
            2'd3:    pio_rdata <= {28'd0, pio_edge};
            default: pio_rdata <= '0;
        endcase
        if (avm_chipselect && !avm_write_n && avm_address == 2'd2) pio_mask <= avm_writedata[3:0];
        if (avm_chipselect && !avm_write_n && avm_address == 2'd3) pio_edge <= press_pulse;
        else pio_edge <= pio_edge | press_pulse;
        if (avm_chipselect && !avm_write_n) wr_log.push_back({avm_address, avm_writedata});
    end

    always @(posedge clk or posedge reset) begin
        if (reset) tb_cyc <= '0;
        else       tb_cyc <= tb_cyc + 32'd1;
    end

    button_pio_irq_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .irq_in         (irq_in),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (pio_rdata),
        .mask_wr_valid  (mask_wr_valid),
        .mask_wr_data   (mask_wr_data),
        .mask_wr_ready  (mask_wr_ready),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_edges      (evt_edges),
        .evt_level      (evt_level),
        .evt_timestamp  (evt_timestamp),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] b);
        press_pulse = b;
        @(negedge clk);
        press_pulse = '0;
    endtask

    task automatic mask_write(input logic [3:0] m);
        int cyc;
        logic [33:0] w;
        cyc = 0;
        mask_wr_data  = m;
        mask_wr_valid = 1'b1;
        #1;
        while (!mask_wr_ready && cyc < 40) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("mask_rdy", 64'(mask_wr_ready), 64'd1);
        @(negedge clk);
        mask_wr_valid = 1'b0;
        @(negedge clk);
        check("mask_nwr", 64'(wr_log.size()), 64'd1);
        if (wr_log.size() != 0) begin
            w = wr_log.pop_front();
            check("mask_wr", 64'(w), 64'({2'd2, 28'd0, m}));
        end
        wr_log.delete();
        cur_mask = m;
    endtask

    // Waits for an event, compares it with the model, then accepts it.
    task automatic collect(input string tag, input logic [3:0] exp_e, input logic [3:0] exp_l,
                           input int exp_lat);
        int cyc;
        logic [31:0] exp_ts;
        logic [33:0] w;
        cyc = 0;
        while (!evt_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_seen"}, 64'(evt_valid), 64'd1);
        if (exp_lat >= 0) check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
`ifdef BTN_EVT_TIMESTAMP_EN
        exp_ts = tb_cyc - 32'd4;
`else
        exp_ts = '0;
`endif
        check({tag, "_edges"}, 64'(evt_edges), 64'(exp_e));
        check({tag, "_level"}, 64'(evt_level), 64'(exp_l));
        check({tag, "_ts"}, 64'(evt_timestamp), 64'(exp_ts));
        check({tag, "_nclr"}, 64'(wr_log.size()), 64'd1);
        if (wr_log.size() != 0) begin
            w = wr_log.pop_front();
            check({tag, "_clraddr"}, 64'(w[33:32]), 64'd3);
        end
        wr_log.delete();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        check({tag, "_drop"}, 64'(evt_valid), 64'd0);
    endtask

    initial begin
        logic [33:0] w;
        logic [3:0]  lvl, m, p;
        bit          stable, saw;

        // Reset state, with a mask request present that must not be accepted
        mask_wr_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cs", 64'(avm_chipselect), 64'd0);
        check("rst_wrn", 64'(avm_write_n), 64'd1);
        check("rst_bus", 64'({avm_address, avm_writedata}), 64'd0);
        check("rst_evt", 64'({evt_valid, evt_edges, evt_level, evt_timestamp}), 64'd0);
        check("rst_rdy", 64'(mask_wr_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        mask_wr_valid = 1'b0;
        reset = 1'b0;

        // Init sequence: mask write, then edge flush
        @(negedge clk);
        check("init_c1", 64'({avm_chipselect, avm_write_n, avm_address, avm_writedata}),
              64'({1'b1, 1'b0, 2'd2, 32'hF}));
        repeat (2) @(negedge clk);
        check("init_nwr", 64'(wr_log.size()), 64'd2);
        if (wr_log.size() == 2) begin
            check("init_w0", 64'(wr_log[0]), 64'({2'd2, 32'hF}));
            check("init_w1", 64'(wr_log[1][33:32]), 64'd3);
        end
        wr_log.delete();
        check("init_idle", 64'(busy), 64'd0);

        // Single service
        pio_level = 4'b1011;
        press(4'b0100);
        pending |= 4'b0100;
        collect("svc", pending, 4'b1011, 6);
        pending = '0;

        // Backpressure with coalesced edges
        press(4'b1000);
        collect("bp_pre", 4'b1000, 4'b1011, 6);
        press(4'b0010);
        repeat (6) @(negedge clk);
        check("bp_first", 64'({evt_valid, evt_edges}), 64'({1'b1, 4'b0010}));
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5)  press_pulse = 4'b0001;
            if (i == 12) press_pulse = 4'b0100;
            @(negedge clk);
            press_pulse = '0;
            if (!evt_valid || evt_edges != 4'b0010 || evt_level != 4'b1011) stable = 1'b0;
        end
        check("bp_stable", 64'(stable), 64'd1);
        check("bp_nclr", 64'(wr_log.size()), 64'd1);
        wr_log.delete();
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        pending = 4'b0101;
        collect("bp_coal", pending, 4'b1011, -1);
        pending = '0;

        // Mask request and irq in the same IDLE cycle: mask goes first
        press_pulse = 4'b0010;
        @(negedge clk);
        press_pulse = '0;
        mask_wr_valid = 1'b1;
        mask_wr_data  = 4'h3;
        #1;
        check("pri_rdy", 64'(mask_wr_ready), 64'd1);
        @(negedge clk);
        mask_wr_valid = 1'b0;
        check("pri_maskcyc", 64'({avm_chipselect, avm_write_n, avm_address, avm_writedata}),
              64'({1'b1, 1'b0, 2'd2, 32'h3}));
        @(negedge clk);
        check("pri_nwr", 64'(wr_log.size()), 64'd1);
        if (wr_log.size() != 0) begin
            w = wr_log.pop_front();
            check("pri_w", 64'(w), 64'({2'd2, 32'h3}));
        end
        wr_log.delete();
        cur_mask = 4'h3;
        collect("pri_evt", 4'b0010, 4'b1011, -1);

        // Spurious irq: edge capture reads zero
        force_irq = 1'b1;
        @(negedge clk);
        force_irq = 1'b0;
        check("spur_busy", 64'(busy), 64'd1);
        saw = 1'b0;
        repeat (8) @(negedge clk) if (evt_valid) saw = 1'b1;
        check("spur_noevt", 64'(saw), 64'd0);
        check("spur_nwr", 64'(wr_log.size()), 64'd0);
        check("spur_idle", 64'(busy), 64'd0);
        wr_log.delete();

        // Randomized masks, presses and levels
        for (int it = 0; it < 8; it++) begin
            lvl = 4'($urandom_range(0, 15));
            pio_level = lvl;
            m = 4'($urandom_range(1, 15));
            p = 4'($urandom_range(1, 15));
            mask_write(m);
            if ((pending & cur_mask) != 0) begin
                collect("rnd_stale", pending, lvl, -1);
                pending = '0;
            end
            press(p);
            pending |= p;
            if ((pending & cur_mask) != 0) begin
                collect("rnd_evt", pending, lvl, 6);
                pending = '0;
            end else begin
                saw = 1'b0;
                repeat (8) @(negedge clk) if (evt_valid || busy) saw = 1'b1;
                check("rnd_quiet", 64'(saw), 64'd0);
            end
        end

        // Reset while the clear write is on the bus
        mask_write(4'hF);
        if (pending != 0) begin
            collect("pre_rst", pending, pio_level, -1);
            pending = '0;
        end
        press(4'b0001);
        repeat (3) @(negedge clk);
        check("mid_clr", 64'({avm_chipselect, avm_write_n, avm_address}), 64'({1'b1, 1'b0, 2'd3}));
        reset = 1'b1;
        #1;
        check("mid_rst_bus", 64'({avm_chipselect, avm_write_n, avm_address, avm_writedata}),
              64'({1'b0, 1'b1, 2'd0, 32'd0}));
        check("mid_rst_st", 64'({busy, evt_valid, evt_edges}), 64'({1'b1, 1'b0, 4'd0}));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wr_log.delete();
        repeat (3) @(negedge clk);
        check("reinit_nwr", 64'(wr_log.size()), 64'd2);
        if (wr_log.size() == 2) begin
            check("reinit_w0", 64'(wr_log[0]), 64'({2'd2, 32'hF}));
            check("reinit_w1", 64'(wr_log[1][33:32]), 64'd3);
        end
        wr_log.delete();
        pending = '0;
        cur_mask = 4'hF;
        pio_level = 4'b0110;
        press(4'b1010);
        collect("post_rst", 4'b1010, 4'b0110, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/button_pio_irq_sequencer.md
Name: button_pio_irq_sequencer

Overview:
Avalon-MM master that owns the 4-bit button PIO slave. It programs the PIO IRQ mask at startup and on request, and services the PIO irq by reading edge_capture, clearing it, then sampling the button levels. Each serviced interrupt becomes one event record on a valid/ready stream for downstream logic. This replaces CPU interrupt handling for buttons in the FPGA fabric.

Parameters:
WIDTH, 4, number of button bits; must be less than or equal to 32.
IRQ_MASK_INIT, 4'hF, mask value written to PIO address 2 after reset.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
irq_in  in  1  PIO irq output
avm_address  out  2  PIO register address
avm_chipselect  out  1  write qualifier
avm_write_n  out  1  active-low write
avm_writedata  out  32  write data
avm_readdata  in  32  PIO readdata; registered, valid 1 cycle after address is driven
mask_wr_valid  in  1  runtime mask update request
mask_wr_data  in  WIDTH  new mask value
mask_wr_ready  out  1  mask update accepted this cycle
evt_valid  out  1  event record valid
evt_ready  in  1  downstream accept
evt_edges  out  WIDTH  captured edge_capture bits
evt_level  out  WIDTH  button levels (PIO address 0) after clear
evt_timestamp  out  32  cycle stamp (see Optional Feature)
busy  out  1  FSM is not in IDLE

Behaviour:
- Reset values: FSM=INIT_MASK; avm_address=0, avm_chipselect=0, avm_write_n=1, avm_writedata=0; evt_valid=0; evt_* data=0; mask_wr_ready=0; busy=1.
- Reset may assert mid-transaction. All state is abandoned, and the init sequence reruns after reset is released.
- The PIO has zero wait states. A write completes in the single cycle in which chipselect=1 and write_n=0. For a read, the FSM drives the address for one cycle and samples avm_readdata at the end of the following cycle.
- All avm_* outputs are registered, one FSM state per bus cycle. Write data is zero-extended to 32 bits.
- FSM states:
  - INIT_MASK: write address 2 with IRQ_MASK_INIT. Next state is INIT_CLR.
  - INIT_CLR: write address 3 to flush stale edges. Next state is IDLE.
  - IDLE: busy=0. If mask_wr_valid=1, pulse mask_wr_ready for 1 cycle, then go to MASK_WR. Otherwise, if irq_in=1, go to RD_EDGE.
  - Mask priority: a mask request has priority over irq when both are present in the same cycle.
  - MASK_WR: write address 2 with mask_wr_data. Next state is IDLE.
  - RD_EDGE: drive address 3. Next state is WAIT_EDGE.
  - WAIT_EDGE: latch readdata[WIDTH-1:0] into evt_edges.
    - If the latched value is 0 (spurious or masked-away irq), go to IDLE and issue no clear.
    - Otherwise, go to CLR_EDGE.
  - CLR_EDGE: write address 3 (clears all bits). Next state is RD_DATA.
  - RD_DATA: drive address 0. Next state is WAIT_DATA.
  - WAIT_DATA: latch evt_level. Next state is EMIT.
  - EMIT: hold evt_valid=1 with stable data until evt_ready=1. On acceptance, go to IDLE with evt_valid=0 in the next cycle.
- Backpressure: while the FSM is in EMIT, no PIO access occurs. New edges stay sticky in the PIO and are delivered coalesced by the next service, so no edge is silently dropped.
- Known window: edges arriving between the RD_EDGE sample and CLR_EDGE are cleared without being reported. This window is 2 cycles and is documented, not fixed.
- Service latency: irq_in high in IDLE gives evt_valid at IDLE+6 cycles.
- mask_wr_ready is high only in IDLE, so a mask request is never accepted mid-service.

Optional Feature:
BTN_EVT_TIMESTAMP_EN:
- Defined: a 32-bit free-running counter (reset to 0, wraps at 2^32-1 to 0) is latched into evt_timestamp in WAIT_EDGE.
- Not defined: the counter is absent and evt_timestamp is tied to 0.

Decomposition:
- Package btn_pio_pkg contains:
  - address constants PIO_ADDR_DATA=2'd0, PIO_ADDR_IRQ_MASK=2'd2, PIO_ADDR_EDGE_CAP=2'd3;
  - the FSM state enum (10 states);
  - the btn_evt_t struct {edges, level, timestamp}.
- Single module; no sub-module is needed. The timestamp counter is inline, under the macro.

Test Plan:
- Release reset -> cycle 1: write addr 2 data 0xF; cycle 2: write addr 3; then busy=0.
- PIO edge_capture=4'b0100 (irq=1), levels=4'b1011 -> exactly one write to addr 3; event edges=4'b0100, level=4'b1011; evt_valid asserted 6 cycles after irq seen in IDLE.
- Hold evt_ready=0 for 20 cycles while pressing button 0 and then button 2 -> first event held stable; after acceptance, second event edges=4'b0101.
- mask_wr_valid with data 4'h3 and irq both high in IDLE -> mask write to addr 2 data 0x3 first, then irq service.
- Spurious: irq high, edge_capture reads 0 -> no clear write, no event, back to IDLE.
- Assert reset in CLR_EDGE -> outputs reach reset values immediately; after release, the init sequence repeats; with macro: timestamp restarts from 0.
